// File: rtl/mips_mem_arbiter_pkg.sv
// rtl/mips_mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mips_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DATA_RD,
      DATA_WR,
      DONE
   } arb_state_t;

   typedef enum logic {
      GNT_FETCH,
      GNT_DATA
   } grant_t;

   // Wide all-ones lane mask; the arbiter slices off DATA_W/8 bits for fetches.
   localparam int                  BE_MAX_W   = 128;
   localparam logic [BE_MAX_W-1:0] BUS_BE_ALL = '1;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - CPU fetch/data ports and Avalon-style bus bundled for the arbiter
interface mips_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_byteenable;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;

   logic [ADDR_W-1:0] bus_address;
   logic              bus_read;
   logic              bus_write;
   logic [DATA_W-1:0] bus_writedata;
   logic [BE_W-1:0]   bus_byteenable;
   logic [DATA_W-1:0] bus_readdata;
   logic              bus_waitrequest;
   logic              bus_err;

   // master: the arbiter, sole master on the memory bus
   modport master (
      input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
      input  bus_readdata, bus_waitrequest,
      output i_rdata, i_done, d_rdata, d_done,
      output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable, bus_err
   );

   // slave: the CPU core plus memory seen from outside the arbiter
   modport slave (
      output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
      output bus_readdata, bus_waitrequest,
      input  i_rdata, i_done, d_rdata, d_done,
      input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable, bus_err
   );

endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - round-robin fetch/data arbiter driving one registered memory bus with timeout
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic               clk,
   input  logic               reset,
   mips_mem_arbiter_if.master mem
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_t        state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   grant_t            gnt_sel;
   logic              data_pend, fetch_pend;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] bus_address_q, bus_address_d;
   logic [DATA_W-1:0] bus_writedata_q, bus_writedata_d;
   logic [BE_W-1:0]   bus_byteenable_q, bus_byteenable_d;
   logic              bus_read_q, bus_read_d;
   logic              bus_write_q, bus_write_d;
   logic              bus_err_q, bus_err_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= GNT_FETCH;
         wait_cnt_q       <= '0;
         bus_address_q    <= '0;
         bus_writedata_q  <= '0;
         bus_byteenable_q <= '0;
         bus_read_q       <= 1'b0;
         bus_write_q      <= 1'b0;
         bus_err_q        <= 1'b0;
         i_rdata_q        <= '0;
         d_rdata_q        <= '0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         wait_cnt_q       <= wait_cnt_d;
         bus_address_q    <= bus_address_d;
         bus_writedata_q  <= bus_writedata_d;
         bus_byteenable_q <= bus_byteenable_d;
         bus_read_q       <= bus_read_d;
         bus_write_q      <= bus_write_d;
         bus_err_q        <= bus_err_d;
         i_rdata_q        <= i_rdata_d;
         d_rdata_q        <= d_rdata_d;
      end
   end

   // last_grant_q is refreshed on every grant, so it also names the port owning the bus.
   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      wait_cnt_d       = wait_cnt_q;
      bus_address_d    = bus_address_q;
      bus_writedata_d  = bus_writedata_q;
      bus_byteenable_d = bus_byteenable_q;
      bus_read_d       = bus_read_q;
      bus_write_d      = bus_write_q;
      bus_err_d        = bus_err_q;
      i_rdata_d        = i_rdata_q;
      d_rdata_d        = d_rdata_q;
      data_pend        = mem.d_read | mem.d_write;
      fetch_pend       = mem.i_req;
      gnt_sel          = GNT_FETCH;

      unique case (state_q)
         IDLE: begin
            if (data_pend || fetch_pend) begin
               if (data_pend && fetch_pend) begin
                  gnt_sel = (last_grant_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
               end else begin
                  gnt_sel = data_pend ? GNT_DATA : GNT_FETCH;
               end
               last_grant_d = gnt_sel;
               wait_cnt_d   = '0;
               if (gnt_sel == GNT_FETCH) begin
                  bus_address_d    = mem.i_addr;
                  bus_byteenable_d = BUS_BE_ALL[BE_W-1:0];
                  bus_read_d       = 1'b1;
                  state_d          = FETCH;
               end else begin
                  bus_address_d    = mem.d_addr;
                  bus_writedata_d  = mem.d_wdata;
                  bus_byteenable_d = mem.d_byteenable;
                  if (mem.d_write) begin
                     bus_write_d = 1'b1;
                     state_d     = DATA_WR;
                  end else begin
                     bus_read_d = 1'b1;
                     state_d    = DATA_RD;
                  end
               end
            end
         end
         FETCH, DATA_RD, DATA_WR: begin
            if (!mem.bus_waitrequest) begin
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
               state_d     = DONE;
               if (state_q == FETCH)   i_rdata_d = mem.bus_readdata;
               if (state_q == DATA_RD) d_rdata_d = mem.bus_readdata;
            end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
               bus_err_d   = 1'b1;
               state_d     = DONE;
               if (last_grant_q == GNT_FETCH) i_rdata_d = '0;
               else                           d_rdata_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem.i_rdata        = i_rdata_q;
   assign mem.d_rdata        = d_rdata_q;
   assign mem.i_done         = (state_q == DONE) && (last_grant_q == GNT_FETCH);
   assign mem.d_done         = (state_q == DONE) && (last_grant_q == GNT_DATA);
   assign mem.bus_address    = bus_address_q;
   assign mem.bus_read       = bus_read_q;
   assign mem.bus_write      = bus_write_q;
   assign mem.bus_writedata  = bus_writedata_q;
   assign mem.bus_byteenable = bus_byteenable_q;
   assign mem.bus_err        = bus_err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - scoreboard bench for mips_mem_arbiter with a stalling memory model
module tb_mips_mem_arbiter;
   localparam int MAX_WAIT = 4;

   typedef struct {
      bit          fetch;
      logic [31:0] rdata;
      bit          chk_rd;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks_n = 0;
   int   errors_n = 0;
   int   stall_n = 0;
   int   sl_cnt = 0;
   int   wr_cnt = 0;
   logic [31:0] wr_last_data;
   exp_t exp_q[$];
   exp_t mon_e;

   mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .mem   (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h2402_0005;
      return ~a ^ 32'h1357_9BDF;
   endfunction

   // Memory model: holds waitrequest for stall_n cycles of each strobe.
   assign ifc.bus_waitrequest = (ifc.bus_read | ifc.bus_write) && (sl_cnt < stall_n);
   assign ifc.bus_readdata    = slave_data(ifc.bus_address);

   always @(posedge clk) begin
      if (!(ifc.bus_read | ifc.bus_write)) sl_cnt <= 0;
      else if (ifc.bus_waitrequest)        sl_cnt <= sl_cnt + 1;
      if (ifc.bus_write && !ifc.bus_waitrequest) begin
         wr_cnt       <= wr_cnt + 1;
         wr_last_data <= ifc.bus_writedata;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_n++;
      if (obs !== exp) begin
         errors_n++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input bit f, input logic [31:0] rd, input bit crd, input int due);
      exp_t e;
      e.fetch = f; e.rdata = rd; e.chk_rd = crd; e.due = due;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (ifc.i_done || ifc.d_done) begin
         check("done_excl", 64'(ifc.i_done & ifc.d_done), 64'd0);
         if (exp_q.size() == 0) begin
            check("done_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("done_port", 64'(ifc.i_done), 64'(mon_e.fetch));
            if (mon_e.chk_rd)
               check("rdata", mon_e.fetch ? 64'(ifc.i_rdata) : 64'(ifc.d_rdata), 64'(mon_e.rdata));
            if (mon_e.due != 0) check("done_cycle", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   task automatic wait_done(input bit fetch);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fetch ? ifc.i_done : ifc.d_done) && n < 64);
      if (!(fetch ? ifc.i_done : ifc.d_done)) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_fetch(input logic [31:0] a);
      @(posedge clk); #1;
      ifc.i_req = 1'b1; ifc.i_addr = a;
      push(1'b1, slave_data(a), 1'b1, cyc + stall_n + 2);
      wait_done(1'b1);
      @(posedge clk); #1;
      ifc.i_req = 1'b0;
   endtask

   task automatic do_tie(input logic [31:0] fa, input logic [31:0] da);
      int c0;
      @(posedge clk); #1;
      c0 = cyc;
      ifc.i_req = 1'b1; ifc.i_addr = fa;
      ifc.d_read = 1'b1; ifc.d_write = 1'b0; ifc.d_addr = da; ifc.d_byteenable = 4'hF;
      push(1'b0, slave_data(da), 1'b1, c0 + 2);
      push(1'b1, slave_data(fa), 1'b1, c0 + 5);
      wait_done(1'b0);
      @(posedge clk); #1;
      ifc.d_read = 1'b0;
      wait_done(1'b1);
      @(posedge clk); #1;
      ifc.i_req = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      int n = 0;
      int wcyc = 0;
      int wr0 = wr_cnt;
      @(posedge clk); #1;
      ifc.d_write = 1'b1; ifc.d_read = 1'b1; ifc.d_addr = a; ifc.d_wdata = wd; ifc.d_byteenable = be;
      push(1'b0, 32'h0, 1'b0, cyc + stall_n + 2);
      do begin
         @(negedge clk);
         n++;
         if (ifc.bus_write) begin
            wcyc++;
            check("wr_addr", 64'(ifc.bus_address), 64'(a));
            check("wr_data", 64'(ifc.bus_writedata), 64'(wd));
            check("wr_be", 64'(ifc.bus_byteenable), 64'(be));
            check("wr_no_read", 64'(ifc.bus_read), 64'd0);
         end
      end while (!ifc.d_done && n < 64);
      check("wr_cycles", 64'(wcyc), 64'(stall_n + 1));
      check("wr_accepted", 64'(wr_cnt - wr0), 64'd1);
      check("wr_slave_data", 64'(wr_last_data), 64'(wd));
      @(posedge clk); #1;
      ifc.d_write = 1'b0; ifc.d_read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      int rcyc;
      reset = 1'b1;
      ifc.i_req = 1'b0; ifc.i_addr = '0;
      ifc.d_read = 1'b0; ifc.d_write = 1'b0; ifc.d_addr = '0; ifc.d_wdata = '0; ifc.d_byteenable = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", 64'({ifc.bus_read, ifc.bus_write}), 64'd0);
      check("rst_done", 64'({ifc.i_done, ifc.d_done}), 64'd0);
      check("rst_err", 64'(ifc.bus_err), 64'd0);
      check("rst_rdata", 64'(ifc.i_rdata | ifc.d_rdata), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Zero-wait fetch: strobe on cycle 1, done on cycle 2.
      @(posedge clk); #1;
      ifc.i_req = 1'b1; ifc.i_addr = 32'hBFC0_0000;
      push(1'b1, 32'h2402_0005, 1'b1, cyc + 2);
      @(negedge clk);
      check("f_no_strobe_c0", 64'(ifc.bus_read), 64'd0);
      @(negedge clk);
      check("f_strobe_c1", 64'(ifc.bus_read), 64'd1);
      check("f_addr", 64'(ifc.bus_address), 64'hBFC0_0000);
      check("f_be_all", 64'(ifc.bus_byteenable), 64'hF);
      wait_done(1'b1);
      @(posedge clk); #1;
      ifc.i_req = 1'b0;

      do_tie(32'h0040_0100, 32'h1000_0040);
      do_tie(32'h0040_0104, 32'h1000_0044);
      do_fetch(32'h0040_0200);

      stall_n = 3;
      do_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);

      // Hung slave on a load.
      stall_n = 1000;
      @(posedge clk); #1;
      ifc.d_read = 1'b1; ifc.d_write = 1'b0; ifc.d_addr = 32'h0000_2000; ifc.d_byteenable = 4'hF;
      push(1'b0, 32'h0, 1'b1, cyc + MAX_WAIT + 2);
      n = 0; rcyc = 0;
      do begin
         @(negedge clk);
         n++;
         if (ifc.bus_read) rcyc++;
      end while (!ifc.d_done && n < 64);
      check("to_strobe_cycles", 64'(rcyc), 64'(MAX_WAIT + 1));
      check("to_err", 64'(ifc.bus_err), 64'd1);
      @(posedge clk); #1;
      ifc.d_read = 1'b0;
      stall_n = 3;
      do_store(32'h0000_1004, 32'h0BAD_F00D, 4'b1100);
      check("to_err_sticky", 64'(ifc.bus_err), 64'd1);

      // Reset while a fetch is stalled on the bus.
      stall_n = 1000;
      @(posedge clk); #1;
      ifc.i_req = 1'b1; ifc.i_addr = 32'hBFC0_0010;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rm_strobe_before", 64'(ifc.bus_read), 64'd1);
      reset = 1'b1; ifc.i_req = 1'b0;
      @(negedge clk);
      check("rm_strobes_after", 64'({ifc.bus_read, ifc.bus_write}), 64'd0);
      check("rm_err_cleared", 64'(ifc.bus_err), 64'd0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rm_no_done", 64'({ifc.i_done, ifc.d_done}), 64'd0);
      end
      stall_n = 0;
      do_fetch(32'hBFC0_0000);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule
